// File: rtl/acc_seq_ctrl_if.sv
// Bundle of requester handshakes, job status and accumulator datapath hookup
// for the accumulator sequencer. slave = controller side, master = environment.
interface acc_seq_ctrl_if #(
  parameter int DATA_W = 6,
  parameter int CNT_W  = 4
);
  logic              i_req0;
  logic [DATA_W-1:0] i_op0;
  logic [CNT_W-1:0]  i_cnt0;
  logic              o_gnt0;
  logic              i_req1;
  logic [DATA_W-1:0] i_op1;
  logic [CNT_W-1:0]  i_cnt1;
  logic              o_gnt1;
  logic              o_busy;
  logic              o_done;
  logic              o_owner;
  logic [DATA_W-1:0] o_result;
  logic              o_ovf;
  logic [DATA_W-1:0] o_operand;
  logic              o_acc_clr;
  logic              o_acc_en;
  logic [DATA_W-1:0] i_acc_data;
  logic              i_acc_ovf;

  modport slave (
    input  i_req0, i_op0, i_cnt0, i_req1, i_op1, i_cnt1, i_acc_data, i_acc_ovf,
    output o_gnt0, o_gnt1, o_busy, o_done, o_owner, o_result, o_ovf,
           o_operand, o_acc_clr, o_acc_en
  );

  modport master (
    output i_req0, i_op0, i_cnt0, i_req1, i_op1, i_cnt1, i_acc_data, i_acc_ovf,
    input  o_gnt0, o_gnt1, o_busy, o_done, o_owner, o_result, o_ovf,
           o_operand, o_acc_clr, o_acc_en
  );
endinterface

// File: rtl/acc_seq_ctrl.sv
// Round-robin sequencer for the shared accumulator: grant, clear, add the
// operand cnt times, capture result and sticky overflow, pulse done.
module acc_seq_ctrl #(
  parameter int DATA_W = 6,
  parameter int CNT_W  = 4
) (
  input  logic           clk,
  input  logic           i_rst_n,
  acc_seq_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, CLR, RUN, SETTLE, DONE} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] op_q, result_q;
  logic [CNT_W-1:0]  cnt_q, run_q;
  logic              owner_q, last_owner_q, sticky_q, en_d_q, ovf_q;
  logic              gnt0, gnt1, acc_en, acc_clr, ovf_hit;

  // carry register is only meaningful the cycle after an enabled add
  assign ovf_hit = bus.i_acc_ovf & en_d_q;

  // arbitration, next state and datapath controls
  always_comb begin
    state_d = state_q;
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    acc_en  = 1'b0;
    acc_clr = 1'b0;
    case (state_q)
      IDLE: begin
        // no grant may escape while reset is held
        if (i_rst_n) begin
          if (bus.i_req0 && (!bus.i_req1 || last_owner_q)) gnt0 = 1'b1;
          else if (bus.i_req1)                             gnt1 = 1'b1;
        end
        if (gnt0 || gnt1) state_d = CLR;
      end
      CLR: begin
        acc_clr = 1'b1;
        state_d = (cnt_q != '0) ? RUN : SETTLE;
      end
      RUN: begin
        acc_en = 1'b1;
        if (run_q == CNT_W'(1)) state_d = SETTLE;
      end
      SETTLE:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // job latch, run counter, overflow tracking and result capture
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      op_q         <= '0;
      cnt_q        <= '0;
      run_q        <= '0;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      sticky_q     <= 1'b0;
      en_d_q       <= 1'b0;
      result_q     <= '0;
      ovf_q        <= 1'b0;
    end else begin
      en_d_q <= acc_en;
      if (gnt0 || gnt1) begin
        op_q         <= gnt1 ? bus.i_op1  : bus.i_op0;
        cnt_q        <= gnt1 ? bus.i_cnt1 : bus.i_cnt0;
        owner_q      <= gnt1;
        last_owner_q <= gnt1;
      end
      if (state_q == CLR) begin
        run_q    <= cnt_q;
        sticky_q <= 1'b0;
      end else begin
        sticky_q <= sticky_q | ovf_hit;
      end
      if (state_q == RUN) run_q <= run_q - CNT_W'(1);
      if (state_q == SETTLE) begin
        result_q <= bus.i_acc_data;
        ovf_q    <= sticky_q | ovf_hit;
      end
    end
  end

  assign bus.o_gnt0    = gnt0;
  assign bus.o_gnt1    = gnt1;
  assign bus.o_busy    = (state_q != IDLE);
  assign bus.o_done    = (state_q == DONE);
  assign bus.o_owner   = owner_q;
  assign bus.o_result  = result_q;
  assign bus.o_ovf     = ovf_q;
  assign bus.o_operand = acc_en ? op_q : '0;
  assign bus.o_acc_clr = acc_clr;
  assign bus.o_acc_en  = acc_en;

endmodule

// File: doc/acc_seq_ctrl.md
Name: acc_seq_ctrl

Overview:
- Sequencer and arbiter for the shared 6-bit accumulator datapath: a 7-bit adder feeding a 6-bit data register plus a per-cycle carry register, with the register output fed back to the adder.
- Arbitrates between two requesters using round-robin.
- Per job: clears the accumulator, applies the granted operand for a requested number of add cycles, accumulates a sticky overflow flag, then returns the result with a done pulse.

Parameters:
DATA_W, 6, width of operand, accumulator data and result.
CNT_W, 4, width of the per-job add count (0..15).

Ports:
clk  input  1  clock.
i_rst_n  input  1  reset, asynchronous, active-low.
i_req0  input  1  requester 0 job request; held until o_gnt0.
i_op0  input  DATA_W  requester 0 operand.
i_cnt0  input  CNT_W  requester 0 number of add cycles.
o_gnt0  output  1  one-cycle grant to requester 0; operand/count latched this cycle.
i_req1, i_op1, i_cnt1, o_gnt1  (as above, requester 1).
o_busy  output  1  high from the cycle after grant through DONE.
o_done  output  1  one-cycle job-complete pulse.
o_owner  output  1  requester of the current or last job.
o_result  output  DATA_W  final accumulator value of the last job.
o_ovf  output  1  sticky: any add in the last job carried out of bit DATA_W-1.
o_operand  output  DATA_W  operand to the adder.
o_acc_clr  output  1  synchronous clear of the accumulator data and carry registers.
o_acc_en  output  1  accumulator load enable (data <= data+operand, carry <= carry-out).
i_acc_data  input  DATA_W  accumulator register output (feedback).
i_acc_ovf  input  1  accumulator carry register output.

Behaviour:
- Reset values:
  - All outputs 0; FSM in IDLE; latched op/cnt 0; ovf_sticky 0.
  - last_owner = 1, so requester 0 wins the first tie.
  - Reset is asynchronous and may occur in any state. The job is abandoned, with no done pulse and no grant.
- FSM states: IDLE, CLR, RUN, SETTLE, DONE.
- IDLE:
  - o_operand = 0, o_acc_en = 0, o_acc_clr = 0.
  - Only one request high: grant it.
  - Both high: grant the requester that is not last_owner.
  - On grant: pulse o_gnt for this cycle only, latch op/cnt, set o_owner and last_owner, go to CLR.
  - Requests are never granted outside IDLE.
- CLR (1 cycle): o_acc_clr = 1, ovf_sticky <= 0, run counter <= latched cnt. Go to RUN if cnt ≠ 0, else SETTLE.
- RUN:
  - o_acc_en = 1, o_operand = latched op.
  - Decrement the counter each cycle; after exactly cnt cycles go to SETTLE.
- SETTLE (1 cycle):
  - o_acc_en = 0.
  - o_result <= i_acc_data.
  - o_ovf <= ovf_sticky | (i_acc_ovf & en_d).
  - Go to DONE.
- DONE (1 cycle): o_done = 1, then IDLE. o_result and o_ovf hold until the next SETTLE.
- Overflow tracking:
  - en_d is o_acc_en registered.
  - ovf_sticky <= ovf_sticky | (i_acc_ovf & en_d) in every cycle after CLR.
  - This catches a carry on every add, not only the last.
- Arithmetic: the datapath computes a modulo 2^DATA_W sum. The controller performs no arithmetic beyond the counter.
- Latency with grant in cycle 0: CLR in cycle 1, RUN in cycles 2..cnt+1, SETTLE in cycle cnt+2, o_done in cycle cnt+3, IDLE in cycle cnt+4.
  - The earliest next grant is cycle cnt+4.
  - cnt = 0: o_done in cycle 3 with result 0, o_ovf 0.
- o_busy = 1 in CLR, RUN, SETTLE and DONE.
- o_operand stays stable throughout RUN. Changes on i_op*/i_cnt* after grant have no effect.

Test Plan:
- Reset, then i_req0 with op=25, cnt=2 → o_gnt0 in cycle 0; o_acc_en high for exactly 2 cycles; o_done in cycle 5 with o_result=50, o_ovf=0, o_owner=0.
- i_req1 with op=25, cnt=3 → o_result=11 (75 mod 64), o_ovf=1, o_owner=1.
- op=40, cnt=3 (adds give 40, 16 with carry, 56) → o_result=56, o_ovf=1 (sticky despite no carry on the last add).
- cnt=0, op=63 → o_acc_en never asserted; o_done 3 cycles after grant; o_result=0, o_ovf=0.
- i_req0 and i_req1 held high continuously after reset → grant order 0, 1, 0, 1; each grant at least cnt+4 cycles apart; no grant while o_busy.
- Assert i_rst_n low mid-RUN → all outputs 0 immediately, no o_done. Release with both requests high → o_gnt0 first.
